// File: rtl/boot_img_chk_pkg.sv
// boot_img_chk_pkg: register map, control/status bit positions and FSM states
package boot_img_chk_pkg;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_BASE = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_SUM  = 2'd3;
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_MATCH = 2;
  localparam int ST_ERR   = 3;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/boot_img_chk_regs.sv
// boot_img_chk_regs: CPU register file (BASE/LEN/EXPECT), control decode and registered read port
module boot_img_chk_regs
  import boot_img_chk_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                cpu_avalid,
  input  logic [1:0]          cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_rvalid,
  input  logic                busy,
  input  logic                done,
  input  logic                match,
  input  logic                err,
  input  logic [DATA_W-1:0]   sum,
  output logic                start,
  output logic                abort,
  output logic [ADDR_W-1:0]   base,
  output logic [LEN_W-1:0]    len,
  output logic [DATA_W-1:0]   exp_sum
);
  logic wr, rd, ctrl_wr;
  logic [3:0] status;
  logic [DATA_W-1:0] rdata_nxt;
  assign wr = cpu_avalid & |cpu_wstrb;
  assign rd = cpu_avalid & ~|cpu_wstrb;
  assign ctrl_wr = wr & (cpu_addr == REG_CTRL);
  assign abort = ctrl_wr & cpu_wdata[CTRL_ABORT];
  assign start = ctrl_wr & cpu_wdata[CTRL_START] & ~cpu_wdata[CTRL_ABORT];
  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done;
    status[ST_MATCH] = match;
    status[ST_ERR] = err;
    rdata_nxt = cpu_addr == REG_CTRL ? DATA_W'(status) :
                cpu_addr == REG_BASE ? DATA_W'(base) :
                cpu_addr == REG_LEN  ? DATA_W'(len) : sum;
  end
  // configuration is frozen while a check runs
  iob_reg_re #(.W(ADDR_W)) base_reg (
    .clk_i, .arst_n_i, .cke_i, .rst_i(1'b0),
    .en_i(wr & ~busy & (cpu_addr == REG_BASE)),
    .data_i({cpu_wdata[ADDR_W-1:2], 2'b00}), .data_o(base)
  );
  iob_reg_re #(.W(LEN_W)) len_reg (
    .clk_i, .arst_n_i, .cke_i, .rst_i(1'b0),
    .en_i(wr & ~busy & (cpu_addr == REG_LEN)),
    .data_i(cpu_wdata[LEN_W-1:0]), .data_o(len)
  );
  iob_reg_re #(.W(DATA_W)) exp_reg (
    .clk_i, .arst_n_i, .cke_i, .rst_i(1'b0),
    .en_i(wr & ~busy & (cpu_addr == REG_SUM)),
    .data_i(cpu_wdata), .data_o(exp_sum)
  );
  iob_reg_re #(.W(1)) rvalid_reg (
    .clk_i, .arst_n_i, .cke_i, .rst_i(1'b0), .en_i(1'b1),
    .data_i(rd), .data_o(cpu_rvalid)
  );
  iob_reg_re #(.W(DATA_W)) rdata_reg (
    .clk_i, .arst_n_i, .cke_i, .rst_i(1'b0), .en_i(rd),
    .data_i(rdata_nxt), .data_o(cpu_rdata)
  );
endmodule

// File: rtl/iob_reg_re.sv
// iob_reg_re: register with async active-low reset, clock enable, sync clear and load enable
module iob_reg_re #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         arst_n_i,
  input  logic         cke_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) data_o <= RST_VAL;
    else if (cke_i) data_o <= rst_i ? RST_VAL : en_i ? data_i : data_o;
endmodule

// File: rtl/boot_img_chk.sv
// boot_img_chk: reads LEN words from SRAM at BASE, sums them and compares with EXPECT
module boot_img_chk
  import boot_img_chk_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                cpu_avalid,
  input  logic [1:0]          cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_rvalid,
  output logic                cpu_ready,
  output logic                sram_avalid,
  output logic [ADDR_W-1:0]   sram_addr,
  input  logic                sram_ready,
  input  logic [DATA_W-1:0]   sram_rdata,
  input  logic                sram_rvalid,
  output logic                busy_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic start, abort, done, match, err;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0] len, idx, nxt;
  logic [DATA_W-1:0] exp_sum, sum;
  logic [TW-1:0] tmo;
  assign cpu_ready = 1'b1;
  assign nxt = idx + LEN_W'(1);
  boot_img_chk_regs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) regs (
    .clk_i, .arst_n_i, .cke_i, .cpu_avalid, .cpu_addr, .cpu_wdata, .cpu_wstrb,
    .cpu_rdata, .cpu_rvalid, .busy(busy_o), .done, .match, .err, .sum,
    .start, .abort, .base, .len, .exp_sum
  );
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      state <= S_IDLE;
      sram_avalid <= 1'b0;
      sram_addr <= '0;
      busy_o <= 1'b0;
      sum <= '0;
      done <= 1'b0;
      match <= 1'b0;
      err <= 1'b0;
      idx <= '0;
      tmo <= '0;
    end else if (cke_i) begin
      if (abort) begin
        state <= S_IDLE;
        sram_avalid <= 1'b0;
        busy_o <= 1'b0;
        done <= 1'b0;
        match <= 1'b0;
      end else case (state)
        S_IDLE: if (start) begin
          sum <= '0;
          done <= 1'b0;
          match <= 1'b0;
          err <= 1'b0;
          idx <= '0;
          busy_o <= 1'b1;
          sram_addr <= base;
          sram_avalid <= len != '0;
          state <= len == '0 ? S_DONE : S_REQ;
        end
        S_REQ: if (sram_ready) begin
          sram_avalid <= 1'b0;
          tmo <= TW'(TIMEOUT);
          state <= S_WAIT;
        end
        S_WAIT: if (sram_rvalid) begin
          sum <= sum + sram_rdata;
          idx <= nxt;
          if (nxt == len) state <= S_DONE;
          else begin
            sram_addr <= base + ADDR_W'({nxt, 2'b00});
            sram_avalid <= 1'b1;
            state <= S_REQ;
          end
        end else if (tmo == '0) begin
          err <= 1'b1;
          state <= S_DONE;
        end else tmo <= tmo - TW'(1);
        S_DONE: begin
          done <= 1'b1;
          busy_o <= 1'b0;
          match <= ~err & (sum == exp_sum);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule
